csr_alu: RTL and testbench
==========================

# csr_alu

Combinational read-modify-write unit for Zicsr instructions in the execute stage of the pipelined RV32 core. It combines the current CSR value with the instruction operand (rs1 value or zero-extended zimm) to produce the new CSR value. It also decides whether the CSR write actually occurs and flags writes to read-only CSRs. A one-stage register copy of the result and write-enable feeds the writeback/CSR-file path.

## Interface
- WIDTH, 32: datapath width in bits.
- clk_i  input  1  core clock; registered outputs update on its rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- csr_control_i  input  2  operation select: `CSR_PASS`, `CSR_SET`, `CSR_CLEAR`, or reserved.
- csr_op_a_i  input  WIDTH  instruction operand (rs1 value or zero-extended zimm).
- csr_data_i  input  WIDTH  current CSR read value.
- csr_valid_i  input  1  a CSR instruction is present in the stage this cycle.
- csr_src_zero_i  input  1  rs1 index or zimm field is zero.
- csr_addr_i  input  12  CSR address.
- csr_result_o  output  WIDTH  combinational new CSR value.
- csr_we_o  output  1  combinational CSR write enable.
- csr_illegal_o  output  1  combinational illegal-write flag.
- csr_result_q_o  output  WIDTH  registered csr_result_o.
- csr_we_q_o  output  1  registered csr_we_o.

## Operation
- Control encodings: `CSR_PASS`=2'b00, `CSR_SET`=2'b01, `CSR_CLEAR`=2'b10, 2'b11 reserved.
- Result by operation:
  - PASS: csr_result_o = csr_op_a_i.
  - SET: csr_result_o = csr_data_i | csr_op_a_i.
  - CLEAR: csr_result_o = csr_data_i & ~csr_op_a_i.
  - Reserved: csr_result_o = csr_data_i.
- csr_result_o depends only on csr_control_i, csr_op_a_i and csr_data_i. It is independent of csr_valid_i, clock and reset.
- Raw write intent:
  - PASS: 1 whenever csr_valid_i=1 (CSRRW always writes).
  - SET/CLEAR: csr_valid_i & ~csr_src_zero_i.
  - Reserved: 0.
- Illegal flag: csr_illegal_o = raw intent & (csr_addr_i[11:10]==2'b11).
- Write enable: csr_we_o = raw intent & ~csr_illegal_o.
- SET/CLEAR with nonzero source but operand value 0 still writes; only csr_src_zero_i suppresses the write.
- All-ones and all-zeros operands have no special cases; there are no carries and no width growth.

## Timing
- csr_result_o, csr_we_o and csr_illegal_o are purely combinational: zero cycles latency, valid within the same evaluation step.
- csr_result_q_o and csr_we_q_o capture csr_result_o and csr_we_o on every rising clk_i. Latency is 1 cycle, with no enable and no stall.
- Reset asserted (reset_n_i=0) immediately forces csr_result_q_o=0 and csr_we_q_o=0, regardless of the clock.
- Reset deasserting mid-instruction: the registers capture the current inputs at the first rising edge after release.
- Combinational outputs are unaffected by reset.

## Configuration
- CSR_ALU_ILLEGAL_CHECK_EN defined: read-only detection is active as described above.
- Not defined: csr_illegal_o is tied 0, and csr_we_o equals raw write intent even for addresses 0xC00–0xFFF.

## Structure
- Control encodings (`CSR_PASS`, `CSR_SET`, `CSR_CLEAR`) live in the shared control macros header/package, alongside the other pipeline control codes.
- The read-only address-range constant (2'b11 in bits [11:10]) belongs in the shared package.
- Sub-module: csr_alu_core, the combinational result mux. The wrapper adds write-enable and illegal logic plus the output register.

## Test plan
- SET: op_a=FFFF_FFFF, data=0000_0000 -> result=FFFF_FFFF. With valid=1 and src_zero=0 -> we=1.
- CLEAR: op_a=0000_00FF, data=FFFF_FFFF -> result=FFFF_FF00. With src_zero=1 -> we=0, result unchanged.
- PASS: op_a=DEAD_BEEF, data=1234_5678 -> result=DEAD_BEEF. With valid=1 and src_zero=1 -> we=1.
- Reserved code 2'b11, data=A5A5_A5A5 -> result=A5A5_A5A5 and we=0.
- PASS to addr=0xC00 with valid=1:
  - Macro defined -> illegal=1, we=0.
  - Macro undefined -> illegal=0, we=1.
- Registered path:
  - Hold reset_n_i=0 -> result_q=0 and we_q=0.
  - Release reset, apply SET FFFF_FFFF|0 -> after the next rising edge result_q=FFFF_FFFF and we_q=1.
  - Assert reset mid-cycle -> both outputs clear immediately.

Source files
------------

// File: rtl/csr_alu_pkg.sv
// Shared Zicsr control codes and the read-only CSR address range.
// Also used by csr_alu when the CSR_ALU_ILLEGAL_CHECK_EN build option is defined.
package csr_alu_pkg;

    typedef enum logic [1:0] {
        CSR_PASS  = 2'b00,
        CSR_SET   = 2'b01,
        CSR_CLEAR = 2'b10,
        CSR_RSVD  = 2'b11
    } csr_ctrl_e;

    // CSR addresses 0xC00-0xFFF are read-only by the privileged architecture.
    localparam logic [1:0] CSR_RO_ADDR_PREFIX = 2'b11;

    function automatic logic csr_addr_is_ro(input logic [1:0] addr_hi);
        return addr_hi == CSR_RO_ADDR_PREFIX;
    endfunction

endpackage

// File: rtl/csr_alu_core.sv
// Combinational CSR read-modify-write result mux (CSRRW / CSRRS / CSRRC).
module csr_alu_core
    import csr_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       ctrl_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] result_o
);

    csr_ctrl_e ctrl;
    assign ctrl = csr_ctrl_e'(ctrl_i);

    always_comb begin
        result_o = data_i;
        case (ctrl)
            CSR_PASS:  result_o = op_a_i;
            CSR_SET:   result_o = data_i | op_a_i;
            CSR_CLEAR: result_o = data_i & ~op_a_i;
            default:   result_o = data_i;
        endcase
    end

endmodule

// File: rtl/csr_alu.sv
// Zicsr execute-stage unit: result mux, write-enable/illegal decode and a one-stage output register.
// Build option: define CSR_ALU_ILLEGAL_CHECK_EN to flag and suppress writes to read-only CSRs.
module csr_alu
    import csr_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [1:0]       csr_control_i,
    input  logic [WIDTH-1:0] csr_op_a_i,
    input  logic [WIDTH-1:0] csr_data_i,
    input  logic             csr_valid_i,
    input  logic             csr_src_zero_i,
    input  logic [11:0]      csr_addr_i,
    output logic [WIDTH-1:0] csr_result_o,
    output logic             csr_we_o,
    output logic             csr_illegal_o,
    output logic [WIDTH-1:0] csr_result_q_o,
    output logic             csr_we_q_o
);

    logic             raw_we;
    logic [WIDTH-1:0] result_d, result_q;
    logic             we_d, we_q;

    csr_alu_core #(.WIDTH(WIDTH)) u_core (
        .ctrl_i   (csr_control_i),
        .op_a_i   (csr_op_a_i),
        .data_i   (csr_data_i),
        .result_o (csr_result_o)
    );

    // CSRRW always writes; CSRRS/CSRRC skip the write only when the source field is x0/zimm=0.
    always_comb begin
        raw_we = 1'b0;
        case (csr_ctrl_e'(csr_control_i))
            CSR_PASS:            raw_we = csr_valid_i;
            CSR_SET, CSR_CLEAR:  raw_we = csr_valid_i & ~csr_src_zero_i;
            default:             raw_we = 1'b0;
        endcase
    end

`ifdef CSR_ALU_ILLEGAL_CHECK_EN
    logic addr_unused;
    assign addr_unused   = ^csr_addr_i[9:0];
    assign csr_illegal_o = raw_we & csr_addr_is_ro(csr_addr_i[11:10]);
`else
    logic addr_unused;
    assign addr_unused   = ^csr_addr_i;
    assign csr_illegal_o = 1'b0;
`endif

    assign csr_we_o = raw_we & ~csr_illegal_o;

    assign result_d = csr_result_o;
    assign we_d     = csr_we_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            result_q <= '0;
            we_q     <= 1'b0;
        end else begin
            result_q <= result_d;
            we_q     <= we_d;
        end
    end

    assign csr_result_q_o = result_q;
    assign csr_we_q_o     = we_q;

endmodule

// File: tb/tb_csr_alu.sv
// Scoreboard bench for csr_alu: stimulus pushes expected values, a monitor pops and compares.
module tb_csr_alu;

    localparam int WIDTH = 32;
`ifdef CSR_ALU_ILLEGAL_CHECK_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       ctrl;
    logic [WIDTH-1:0] op_a, data;
    logic             valid, src_zero;
    logic [11:0]      addr;
    logic [WIDTH-1:0] result, result_q;
    logic             we, illegal, we_q;

    always #5 clk = ~clk;

    csr_alu #(.WIDTH(WIDTH)) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .csr_control_i  (ctrl),
        .csr_op_a_i     (op_a),
        .csr_data_i     (data),
        .csr_valid_i    (valid),
        .csr_src_zero_i (src_zero),
        .csr_addr_i     (addr),
        .csr_result_o   (result),
        .csr_we_o       (we),
        .csr_illegal_o  (illegal),
        .csr_result_q_o (result_q),
        .csr_we_q_o     (we_q)
    );

    typedef struct {
        bit          is_reg;
        logic [31:0] res;
        logic        we;
        logic        ill;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    event ev;
    int checks = 0;
    int failures = 0;

    // Monitor: one expected entry per sample event, checked 1 time unit later.
    initial begin
        forever begin
            @(ev);
            #1;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: sample event with empty queue");
            end else begin
                mon_e = q.pop_front();
                if (!mon_e.is_reg) begin
                    checks++;
                    if (result !== mon_e.res) begin
                        failures++;
                        $display("FAIL %s result got=%h exp=%h", mon_e.name, result, mon_e.res);
                    end
                    checks++;
                    if (we !== mon_e.we) begin
                        failures++;
                        $display("FAIL %s we got=%b exp=%b", mon_e.name, we, mon_e.we);
                    end
                    checks++;
                    if (illegal !== mon_e.ill) begin
                        failures++;
                        $display("FAIL %s illegal got=%b exp=%b", mon_e.name, illegal, mon_e.ill);
                    end
                end else begin
                    checks++;
                    if (result_q !== mon_e.res) begin
                        failures++;
                        $display("FAIL %s result_q got=%h exp=%h", mon_e.name, result_q, mon_e.res);
                    end
                    checks++;
                    if (we_q !== mon_e.we) begin
                        failures++;
                        $display("FAIL %s we_q got=%b exp=%b", mon_e.name, we_q, mon_e.we);
                    end
                end
            end
        end
    end

    task automatic push_chk(input bit is_reg, input logic [31:0] res, input logic w,
                            input logic il, input string nm);
        exp_t e;
        e.is_reg = is_reg;
        e.res    = res;
        e.we     = w;
        e.ill    = il;
        e.name   = nm;
        q.push_back(e);
        -> ev;
        #2;
    endtask

    // Drive one vector at negedge, check the combinational outputs, then the registered copy.
    task automatic apply(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                         input logic v, input logic sz, input logic [11:0] ad,
                         input logic [31:0] er, input logic ew, input logic ei,
                         input string nm);
        @(negedge clk);
        ctrl     = c;
        op_a     = a;
        data     = d;
        valid    = v;
        src_zero = sz;
        addr     = ad;
        push_chk(1'b0, er, ew, ei, nm);
        @(posedge clk);
        #1;
        push_chk(1'b1, er, ew, 1'b0, {nm, "_q"});
    endtask

    initial begin
        reset_n  = 1'b0;
        ctrl     = 2'b01;
        op_a     = 32'hFFFF_FFFF;
        data     = 32'h0000_0000;
        valid    = 1'b1;
        src_zero = 1'b0;
        addr     = 12'h300;

        #2;
        push_chk(1'b1, 32'h0, 1'b0, 1'b0, "reset_state_q");
        push_chk(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "comb_in_reset");
        @(posedge clk);
        #1;
        push_chk(1'b1, 32'h0, 1'b0, 1'b0, "reset_hold_q");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push_chk(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, "first_capture_q");

        apply(2'b01, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 12'h300, 32'hFFFF_FFFF, 1, 0, "set_ones");
        apply(2'b10, 32'h0000_00FF, 32'hFFFF_FFFF, 1, 1, 12'h300, 32'hFFFF_FF00, 0, 0, "clear_srczero");
        apply(2'b10, 32'h0000_00FF, 32'hFFFF_FFFF, 1, 0, 12'h300, 32'hFFFF_FF00, 1, 0, "clear_write");
        apply(2'b00, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1, 12'h300, 32'hDEAD_BEEF, 1, 0, "pass_srczero");
        apply(2'b11, 32'h1234_5678, 32'hA5A5_A5A5, 1, 0, 12'h300, 32'hA5A5_A5A5, 0, 0, "reserved");
        apply(2'b00, 32'hCAFE_F00D, 32'h0000_0000, 1, 0, 12'hC00, 32'hCAFE_F00D, !ILL, ILL, "pass_ro_c00");
        apply(2'b01, 32'h0000_0000, 32'h0F0F_0F0F, 1, 0, 12'h300, 32'h0F0F_0F0F, 1, 0, "set_zero_operand");
        apply(2'b01, 32'h0000_00F0, 32'h0000_000F, 0, 0, 12'h300, 32'h0000_00FF, 0, 0, "set_invalid");
        apply(2'b10, 32'h0000_FFFF, 32'h1234_5678, 1, 0, 12'hFFF, 32'h1234_0000, !ILL, ILL, "clear_ro_fff");
        apply(2'b01, 32'h0000_0001, 32'h0000_0002, 1, 1, 12'hC00, 32'h0000_0003, 0, 0, "set_ro_srczero");
        apply(2'b00, 32'h0000_0000, 32'hFFFF_FFFF, 1, 0, 12'hBFF, 32'h0000_0000, 1, 0, "pass_bff");
        apply(2'b00, 32'hDEAD_BEEF, 32'h0000_0000, 1, 0, 12'h340, 32'hDEAD_BEEF, 1, 0, "pass_last");

        // Asynchronous reset between clock edges; combinational path must be unaffected.
        reset_n = 1'b0;
        push_chk(1'b1, 32'h0, 1'b0, 1'b0, "async_reset_q");
        push_chk(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, "comb_during_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        push_chk(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, "capture_after_release_q");

        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_drain: pending=%0d exp=0", q.size());
        end
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
